// File: rtl/airlock_if.sv
// Request/close inputs and door/pump/status outputs of the lab-2 airlock sequencer.
// The slave modport is the sequencer side; the master modport is the driving/observing side.
interface airlock_if;
    logic arrive_req;
    logic depart_req;
    logic outer_close;
    logic inner_close;
    logic outer_open;
    logic inner_open;
    logic evacuating;
    logic pressurizing;
    logic pressurized;
    logic busy;
    logic arrive_done;
    logic depart_done;

    modport slave (
        input  arrive_req, depart_req, outer_close, inner_close,
        output outer_open, inner_open, evacuating, pressurizing,
        output pressurized, busy, arrive_done, depart_done
    );

    modport master (
        output arrive_req, depart_req, outer_close, inner_close,
        input  outer_open, inner_open, evacuating, pressurizing,
        input  pressurized, busy, arrive_done, depart_done
    );
endinterface

// File: rtl/airlock_sequencer.sv
// Chamber-side airlock sequencer: services latched arrival/departure requests through
// evacuate/fill phases and door openings, skipping phases the chamber state already satisfies.
module airlock_sequencer #(
    parameter int FILL_CYCLES = 7,
    parameter int EVAC_CYCLES = 7,
    parameter int CNT_W       = 10
) (
    input  logic      clk,
    input  logic      rst,
    airlock_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        EVAC,
        OPEN_OUTER,
        FILL,
        OPEN_INNER
    } stateT;

    typedef enum logic {
        ARRIVE,
        DEPART
    } modeT;

    localparam logic [CNT_W-1:0] EVAC_LAST = CNT_W'(EVAC_CYCLES - 1);
    localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(FILL_CYCLES - 1);

    stateT            state;
    modeT             mode;
    logic [CNT_W-1:0] phaseCnt;
    logic             arrQ, depQ;
    logic             pendArr, pendDep;
    logic             outerOpen, innerOpen, evacOn, fillOn;
    logic             pressurizedQ, busyQ, arriveDone, departDone;

    logic arrEdge, depEdge, takeArr, takeDep;

    assign arrEdge = bus.arrive_req & ~arrQ;
    assign depEdge = bus.depart_req & ~depQ;
    // Arrival wins when both are pending; the loser stays latched for the next IDLE cycle.
    assign takeArr = (state == IDLE) & pendArr;
    assign takeDep = (state == IDLE) & ~pendArr & pendDep;

    // NOTE: all state here uses non-blocking assignments so every register samples the
    // pre-edge values, independent of statement order inside the block.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            mode         <= ARRIVE;
            phaseCnt     <= '0;
            arrQ         <= 1'b0;
            depQ         <= 1'b0;
            pendArr      <= 1'b0;
            pendDep      <= 1'b0;
            outerOpen    <= 1'b0;
            innerOpen    <= 1'b0;
            evacOn       <= 1'b0;
            fillOn       <= 1'b0;
            pressurizedQ <= 1'b1;
            busyQ        <= 1'b0;
            arriveDone   <= 1'b0;
            departDone   <= 1'b0;
        end else begin
            arrQ       <= bus.arrive_req;
            depQ       <= bus.depart_req;
            pendArr    <= (pendArr & ~takeArr) | arrEdge;
            pendDep    <= (pendDep & ~takeDep) | depEdge;
            arriveDone <= 1'b0;
            departDone <= 1'b0;

            case (state)
                IDLE: begin
                    if (takeArr) begin
                        mode  <= ARRIVE;
                        busyQ <= 1'b1;
                        if (pressurizedQ) begin
                            state  <= EVAC;
                            evacOn <= 1'b1;
                        end else begin
                            state     <= OPEN_OUTER;
                            outerOpen <= 1'b1;
                        end
                    end else if (takeDep) begin
                        mode  <= DEPART;
                        busyQ <= 1'b1;
                        if (pressurizedQ) begin
                            state     <= OPEN_INNER;
                            innerOpen <= 1'b1;
                        end else begin
                            state  <= FILL;
                            fillOn <= 1'b1;
                        end
                    end
                end

                EVAC: begin
                    if (phaseCnt == EVAC_LAST) begin
                        phaseCnt     <= '0;
                        pressurizedQ <= 1'b0;
                        evacOn       <= 1'b0;
                        state        <= OPEN_OUTER;
                        outerOpen    <= 1'b1;
                    end else begin
                        phaseCnt <= phaseCnt + CNT_W'(1);
                    end
                end

                FILL: begin
                    if (phaseCnt == FILL_LAST) begin
                        phaseCnt     <= '0;
                        pressurizedQ <= 1'b1;
                        fillOn       <= 1'b0;
                        state        <= OPEN_INNER;
                        innerOpen    <= 1'b1;
                    end else begin
                        phaseCnt <= phaseCnt + CNT_W'(1);
                    end
                end

                OPEN_OUTER: begin
                    if (bus.outer_close) begin
                        outerOpen <= 1'b0;
                        if (mode == ARRIVE) begin
                            state  <= FILL;
                            fillOn <= 1'b1;
                        end else begin
                            state      <= IDLE;
                            busyQ      <= 1'b0;
                            departDone <= 1'b1;
                        end
                    end
                end

                OPEN_INNER: begin
                    if (bus.inner_close) begin
                        innerOpen <= 1'b0;
                        if (mode == DEPART) begin
                            state  <= EVAC;
                            evacOn <= 1'b1;
                        end else begin
                            state      <= IDLE;
                            busyQ      <= 1'b0;
                            arriveDone <= 1'b1;
                        end
                    end
                end

                default: begin
                    state     <= IDLE;
                    busyQ     <= 1'b0;
                    outerOpen <= 1'b0;
                    innerOpen <= 1'b0;
                    evacOn    <= 1'b0;
                    fillOn    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.outer_open   = outerOpen;
    assign bus.inner_open   = innerOpen;
    assign bus.evacuating   = evacOn;
    assign bus.pressurizing = fillOn;
    assign bus.pressurized  = pressurizedQ;
    assign bus.busy         = busyQ;
    assign bus.arrive_done  = arriveDone;
    assign bus.depart_done  = departDone;

endmodule
